// File: rtl/async_operator_fifo.sv
// async_operator_fifo: collects one operand per input channel, applies op, queues the result
// and fans each FIFO entry out to every consumer exactly once.
module async_operator_fifo #(
    parameter int data_width = 32,
    parameter int input_size = 2,
    parameter int output_size = 2,
    parameter int depth = 4,
    parameter string op = "add",
    parameter logic [data_width-1:0] immediate = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic [input_size-1:0]            req_l,
    input  logic [input_size-1:0]            ack_l,
    input  logic [data_width*input_size-1:0] din,
    input  logic [output_size-1:0]           req_r,
    output logic [output_size-1:0]           ack_r,
    output logic [data_width-1:0]            dout,
    output logic [$clog2(depth+1)-1:0]       level
);
    localparam int aw = $clog2(depth);
    localparam int lw = $clog2(depth+1);

    logic [data_width-1:0]  opnd [input_size];
    logic [data_width-1:0]  mem [depth];
    logic [input_size-1:0]  has, cap;
    logic [output_size-1:0] sv, grant;
    logic [aw-1:0]          wr_ptr, rd_ptr;
    logic [data_width-1:0]  res;
    logic                   push, pop;

    assign cap   = ack_l & req_l;
    assign pop   = &sv;
    assign push  = &has & (level < lw'(depth) | pop);
    assign grant = req_r & ~sv & ~ack_r & {output_size{level != '0 && !pop}};
    assign dout  = level == '0 ? '0 : mem[rd_ptr];

    // Multi-operand ops fold left from opnd0; immediate ops only look at opnd0.
    always_comb begin
        res = opnd[0];
        for (int i = 1; i < input_size; i++)
            res = op == "sub" ? res - opnd[i] : op == "mul" ? res * opnd[i] : res + opnd[i];
        res = op == "addi" ? opnd[0] + immediate :
              op == "subi" ? opnd[0] - immediate :
              op == "muli" ? opnd[0] * immediate : res;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            req_l  <= '0;
            has    <= '0;
            sv     <= '0;
            ack_r  <= '0;
            level  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < input_size; i++) opnd[i] <= '0;
        end else begin
            for (int i = 0; i < input_size; i++)
                if (cap[i]) opnd[i] <= din[data_width*i +: data_width];
            has    <= push ? '0 : has | cap;
            // a capture always drops its request; otherwise re-arm idle channels
            req_l  <= ~cap & (push ? '1 : req_l | ~has);
            sv     <= pop ? '0 : sv | grant;
            ack_r  <= grant;
            level  <= level + lw'(push) - lw'(pop);
            if (push) wr_ptr <= wr_ptr + aw'(1);
            if (pop) rd_ptr <= rd_ptr + aw'(1);
        end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= res;
endmodule

// File: tb/tb_async_operator_fifo.sv
// tb_async_operator_fifo: random producer/consumer traffic against a queue-based model,
// plus directed fan-out skew, full-throughput, spurious-ack, immediate-op and async-reset cases.
module tb_async_operator_fifo;
    localparam int dw = 32, ni = 2, no = 2, dp = 4;

    logic clk = 0, rst = 1;
    logic [ni-1:0] req_l, ack_l = '0;
    logic [dw*ni-1:0] din = '0;
    logic [no-1:0] req_r = '0, ack_r;
    logic [dw-1:0] dout;
    logic [2:0] level;

    logic s_req_l, s_ack_l = 0, s_req_r = 0, s_ack_r;
    logic m_req_l, m_ack_l = 0, m_req_r = 0, m_ack_r;
    logic [dw-1:0] s_din = '0, s_dout, m_din = '0, m_dout;
    logic [1:0] s_level, m_level;

    int checks = 0, errors = 0;
    logic [dw-1:0] ch [ni][$];
    logic [dw-1:0] res_q [$];
    int k [no];
    int acks [no];
    int prod_pct = 0, spur_pct = 0, cons_pct = 0;
    logic [no-1:0] cons_en = '1;

    always #5 clk = ~clk;

    async_operator_fifo #(.data_width(dw), .input_size(ni), .output_size(no), .depth(dp), .op("add")) dut (
        .clk(clk), .rst(rst), .req_l(req_l), .ack_l(ack_l), .din(din),
        .req_r(req_r), .ack_r(ack_r), .dout(dout), .level(level));

    async_operator_fifo #(.data_width(dw), .input_size(1), .output_size(1), .depth(2), .op("subi"), .immediate(32'd5)) u_subi (
        .clk(clk), .rst(rst), .req_l(s_req_l), .ack_l(s_ack_l), .din(s_din),
        .req_r(s_req_r), .ack_r(s_ack_r), .dout(s_dout), .level(s_level));

    async_operator_fifo #(.data_width(dw), .input_size(1), .output_size(1), .depth(2), .op("muli"), .immediate(32'd3)) u_muli (
        .clk(clk), .rst(rst), .req_l(m_req_l), .ack_l(m_ack_l), .din(m_din),
        .req_r(m_req_r), .ack_r(m_ack_r), .dout(m_dout), .level(m_level));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: score acks seen after the last edge, then drive inputs for the next edge.
    task automatic step();
        logic [dw-1:0] v;
        @(negedge clk);
        for (int j = 0; j < no; j++)
            if (ack_r[j]) begin
                if (k[j] < res_q.size()) check($sformatf("c%0d_entry%0d", j, k[j]), dout, res_q[k[j]]);
                else check($sformatf("c%0d_extra", j), k[j] + 1, res_q.size());
                k[j]++;
                acks[j]++;
            end
        if (level == 0) check("dout_empty", dout, 0);
        if (level > dp) check("level_max", 32'(level), dp);
        for (int i = 0; i < ni; i++) begin
            v = $urandom;
            din[dw*i +: dw] = v;
            ack_l[i] = $urandom_range(99) < (req_l[i] ? prod_pct : spur_pct);
            if (ack_l[i] && req_l[i]) ch[i].push_back(v);
        end
        if (ch[0].size() > 0 && ch[1].size() > 0) res_q.push_back(ch[0].pop_front() + ch[1].pop_front());
        for (int j = 0; j < no; j++) req_r[j] = cons_en[j] && $urandom_range(99) < cons_pct;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        prod_pct = 0; spur_pct = 0; cons_pct = 100; cons_en = '1;
        while ((level != 0 || k[0] != res_q.size() || k[1] != res_q.size()) && n < 300) begin
            step();
            n++;
        end
        check({tag, "_c0_count"}, k[0], res_q.size());
        check({tag, "_c1_count"}, k[1], res_q.size());
        check({tag, "_level"}, 32'(level), 0);
    endtask

    initial begin
        int n, a0;
        for (int j = 0; j < no; j++) begin k[j] = 0; acks[j] = 0; end
        repeat (2) @(negedge clk);
        check("rst_req_l", 32'(req_l), 0);
        check("rst_ack_r", 32'(ack_r), 0);
        check("rst_level", 32'(level), 0);
        check("rst_dout", dout, 0);
        rst = 0;

        n = 0;
        while (!(s_req_l && m_req_l) && n < 20) begin @(negedge clk); n++; end
        check("imm_req_l", 32'({s_req_l, m_req_l}), 3);
        s_din = 32'd3; m_din = 32'h6000_0000; s_ack_l = 1; m_ack_l = 1;
        @(negedge clk);
        s_ack_l = 0; m_ack_l = 0; s_req_r = 1; m_req_r = 1;
        n = 0;
        while (!s_ack_r && n < 20) begin @(negedge clk); n++; end
        check("subi", s_dout, 32'hFFFF_FFFE);
        n = 0;
        while (!m_ack_r && n < 20) begin @(negedge clk); n++; end
        check("muli", m_dout, 32'h2000_0000);
        s_req_r = 0; m_req_r = 0;

        prod_pct = 70; spur_pct = 20; cons_pct = 60;
        repeat (1500) step();
        drain("rand1");

        prod_pct = 100; spur_pct = 0; cons_pct = 100; cons_en = 2'b01;
        a0 = acks[0];
        repeat (30) step();
        check("skew_c0_acks", acks[0] - a0, 1);
        check("skew_level", 32'(level), dp);
        check("skew_req_l", 32'(req_l), 0);
        spur_pct = 100;
        repeat (5) step();
        check("spur_level", 32'(level), dp);
        check("spur_req_l", 32'(req_l), 0);
        spur_pct = 0; cons_en = '1;
        step();
        repeat (16) begin
            step();
            check("full_level", 32'(level), dp);
        end

        prod_pct = 70; spur_pct = 20; cons_pct = 60;
        repeat (1500) step();
        drain("rand2");

        cons_en = '0; prod_pct = 100; spur_pct = 0;
        n = 0;
        do begin step(); n++; end while (level != 3 && n < 100);
        check("pre_rst_level", 32'(level), 3);
        #2 rst = 1;
        #1;
        check("arst_req_l", 32'(req_l), 0);
        check("arst_ack_r", 32'(ack_r), 0);
        check("arst_level", 32'(level), 0);
        check("arst_dout", dout, 0);
        ack_l = '0;
        for (int i = 0; i < ni; i++) ch[i].delete();
        res_q.delete();
        for (int j = 0; j < no; j++) k[j] = 0;
        @(negedge clk);
        rst = 0;
        cons_en = '1; prod_pct = 80; spur_pct = 10; cons_pct = 80;
        repeat (500) step();
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end
endmodule
